// File: rtl/gamepad_pmod_pkg.sv
// Shared constants for the gamepad Pmod transmit and receive paths.
// Holds the per-pad word width, the word sent for an absent pad, the
// button bit positions within a pad word, and the emulator FSM states.
package gamepad_pmod_pkg;

  localparam int unsigned PAD_BITS = 12;
  localparam logic [PAD_BITS-1:0] ABSENT_WORD = 12'hFFF;

  // Bit positions inside one 12-bit pad word (MSB first on the wire)
  localparam int unsigned BTN_B      = 11;
  localparam int unsigned BTN_Y      = 10;
  localparam int unsigned BTN_SELECT = 9;
  localparam int unsigned BTN_START  = 8;
  localparam int unsigned BTN_UP     = 7;
  localparam int unsigned BTN_DOWN   = 6;
  localparam int unsigned BTN_LEFT   = 5;
  localparam int unsigned BTN_RIGHT  = 4;
  localparam int unsigned BTN_A      = 3;
  localparam int unsigned BTN_X      = 2;
  localparam int unsigned BTN_L      = 1;
  localparam int unsigned BTN_R      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_LATCH,
    ST_GAP
  } pmod_state_e;

endpackage

// File: rtl/gamepad_pmod_emulator_if.sv
// 3-wire gamepad Pmod link.
//   pmod_data  : serial data, frame MSB first
//   pmod_clk   : serial clock, receiver samples on rising edge
//   pmod_latch : frame latch pulse, receiver transfers on rising edge
// master = transmitter (emulator), slave = receiver.
interface gamepad_pmod_emulator_if;
  logic pmod_data;
  logic pmod_clk;
  logic pmod_latch;

  modport master (output pmod_data, pmod_clk, pmod_latch);
  modport slave  (input  pmod_data, pmod_clk, pmod_latch);
endinterface

// File: rtl/gamepad_pmod_emulator.sv
// Gamepad Pmod transmitter: serializes 1 or 2 pads of button states onto
// the 3-wire Pmod link (data/clk/latch), for driving the receive path in
// simulation, keyboard bridging and loopback self-test.
// Ports:
//   clk, rst_n   : system clock, synchronous active-low reset
//   enable       : 1 = send frames back-to-back, 0 = stop after current frame
//   buttons      : pad p in [12p+11:12p], 1 = pressed
//   pad_present  : 0 = pad absent, sent as all ones
//   pmod         : serial link (master side)
//   busy         : high from LOAD through LATCH
//   frame_done   : one-cycle pulse in the first GAP cycle
// All outputs are flops; they are loaded from the next-state values so each
// registered output reflects the state the FSM is in during that cycle.
module gamepad_pmod_emulator
  import gamepad_pmod_pkg::*;
#(
  parameter int NUM_PADS  = 2,
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [PAD_BITS*NUM_PADS-1:0] buttons,
  input  logic [NUM_PADS-1:0]          pad_present,
  gamepad_pmod_emulator_if.master      pmod,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int W       = PAD_BITS * NUM_PADS;
  localparam int CNT_MAX = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BCW     = $clog2(W + 1);

  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(FRAME_GAP - 1);
  localparam logic [BCW-1:0]   BITS_LOAD  = BCW'(W);

  pmod_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [W-1:0]     shift, shift_nxt;
  logic [W-1:0]     frame_word;

  logic data_nxt, sclk_nxt, latch_nxt, busy_nxt, done_nxt;

  always_comb begin
    frame_word = '0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      frame_word[p*PAD_BITS +: PAD_BITS] =
        pad_present[p] ? buttons[p*PAD_BITS +: PAD_BITS] : ABSENT_WORD;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;

    unique case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        shift_nxt   = frame_word;
        bit_cnt_nxt = BITS_LOAD;
        state_nxt   = ST_BIT_LOW;
      end
      ST_BIT_LOW: begin
        if (cnt == '0) state_nxt = ST_BIT_HIGH;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_BIT_HIGH: begin
        if (cnt == '0) begin
          shift_nxt   = {shift[W-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt - 1'b1;
          state_nxt   = (bit_cnt_nxt != '0) ? ST_BIT_LOW : ST_LATCH;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_LATCH: begin
        if (cnt == '0) state_nxt = ST_GAP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_GAP: begin
        if (cnt == '0) state_nxt = enable ? ST_LOAD : ST_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Phase counter restarts on every state change
    if (state_nxt != state) begin
      unique case (state_nxt)
        ST_BIT_LOW, ST_BIT_HIGH, ST_LATCH: cnt_nxt = DIV_RELOAD;
        ST_GAP:                            cnt_nxt = GAP_RELOAD;
        default:                           cnt_nxt = '0;
      endcase
    end

    data_nxt  = ((state_nxt == ST_BIT_LOW) || (state_nxt == ST_BIT_HIGH))
                ? shift_nxt[W-1] : 1'b0;
    sclk_nxt  = (state_nxt == ST_BIT_HIGH);
    latch_nxt = (state_nxt == ST_LATCH);
    busy_nxt  = (state_nxt == ST_LOAD) || (state_nxt == ST_BIT_LOW) ||
                (state_nxt == ST_BIT_HIGH) || (state_nxt == ST_LATCH);
    done_nxt  = (state_nxt == ST_GAP) && (state != ST_GAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      pmod.pmod_data  <= 1'b0;
      pmod.pmod_clk   <= 1'b0;
      pmod.pmod_latch <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bit_cnt         <= bit_cnt_nxt;
      shift           <= shift_nxt;
      pmod.pmod_data  <= data_nxt;
      pmod.pmod_clk   <= sclk_nxt;
      pmod.pmod_latch <= latch_nxt;
      busy            <= busy_nxt;
      frame_done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_emulator.sv
// Self-checking bench for gamepad_pmod_emulator (NUM_PADS=2, defaults).
// A line monitor acts as the receiver: shifts data on pmod_clk rising
// edges and captures the word on pmod_latch rising edges.
module tb_gamepad_pmod_emulator;

  localparam int NP     = 2;
  localparam int CDIV   = 4;
  localparam int GAP    = 64;
  localparam int W      = 12 * NP;
  localparam int PERIOD = 1 + 2 * CDIV * W + CDIV + GAP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [W-1:0]  buttons = '0;
  logic [NP-1:0] pad_present = '0;
  logic          busy, frame_done;

  gamepad_pmod_emulator_if pif ();

  gamepad_pmod_emulator #(
    .NUM_PADS (NP),
    .CLK_DIV  (CDIV),
    .FRAME_GAP(GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .buttons    (buttons),
    .pad_present(pad_present),
    .pmod       (pif.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // receiver / monitor state
  logic [W-1:0] rx_shift = '0;
  logic [W-1:0] rx_word = '0;
  int rx_bits = 0, rx_frame_bits = 0, latch_cnt = 0;
  int lat_run = 0, last_lat_len = 0;
  int done_cnt = 0, cyc = 0, last_done_cyc = 0, last_done_gap = 0;
  logic prev_sclk = 1'b0, prev_latch = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (pif.pmod_clk && !prev_sclk) begin
      rx_shift = {rx_shift[W-2:0], pif.pmod_data};
      rx_bits++;
    end
    if (pif.pmod_latch && !prev_latch) begin
      rx_word       = rx_shift;
      rx_frame_bits = rx_bits;
      rx_bits       = 0;
      latch_cnt++;
    end
    if (pif.pmod_latch) lat_run++;
    else if (prev_latch) begin
      last_lat_len = lat_run;
      lat_run      = 0;
    end
    if (frame_done) begin
      done_cnt++;
      last_done_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
    end
    prev_sclk  = pif.pmod_clk;
    prev_latch = pif.pmod_latch;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_latch(input string name);
    int  old = latch_cnt;
    bit  got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      #1;
      if (latch_cnt != old) got = 1'b1;
    end
    check({name, "_latch_timeout"}, 32'(got), 32'd1);
  endtask

  // Reference: each pad contributes its 12 buttons if present, else 4095;
  // pad 1 is the high-order 12 bits of the transmitted word.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] b, input logic [NP-1:0] p);
    int unsigned pad_val [NP];
    int unsigned word = 0;
    for (int k = 0; k < NP; k++) begin
      pad_val[k] = p[k] ? ((b >> (12 * k)) % 4096) : 4095;
      word += pad_val[k] * (4096 ** k);
    end
    return W'(word);
  endfunction

  typedef struct {
    logic [W-1:0]  btn;
    logic [NP-1:0] pres;
    logic [W-1:0]  exp_word;
    logic [NP-1:0] exp_dec;   // receiver's view of is_present
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [W-1:0]  rb, nb;
    logic [NP-1:0] rp;
    logic [W-1:0]  exp_q [$];
    logic [NP-1:0] dec;
    int l0, d0;
    bit got;

    tbl[0] = '{24'h010801, 2'b11, 24'h010801, 2'b11};
    tbl[1] = '{24'h0F0801, 2'b01, 24'hFFF801, 2'b01};
    tbl[2] = '{24'h456123, 2'b10, 24'h456FFF, 2'b10};
    tbl[3] = '{24'h0A50C3, 2'b00, 24'hFFFFFF, 2'b00};
    tbl[4] = '{24'hFFF000, 2'b11, 24'hFFF000, 2'b01};

    // reset state
    cyc_wait(3);
    check("rst_data",  32'(pif.pmod_data),  32'd0);
    check("rst_clk",   32'(pif.pmod_clk),   32'd0);
    check("rst_latch", 32'(pif.pmod_latch), 32'd0);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_done",  32'(frame_done),     32'd0);
    rst_n = 1'b1;
    cyc_wait(2);

    // table-driven single frames
    for (int i = 0; i < 5; i++) begin
      rx_bits     = 0;
      buttons     = tbl[i].btn;
      pad_present = tbl[i].pres;
      enable      = 1'b1;
      wait_latch($sformatf("tbl%0d", i));
      enable = 1'b0;
      check($sformatf("tbl%0d_word", i), 32'(rx_word), 32'(tbl[i].exp_word));
      check($sformatf("tbl%0d_bits", i), 32'(rx_frame_bits), 32'd24);
      for (int k = 0; k < NP; k++) dec[k] = (rx_word[12*k +: 12] != 12'hFFF);
      check($sformatf("tbl%0d_present", i), 32'(dec), 32'(tbl[i].exp_dec));
      cyc_wait(GAP + 2 * CDIV);
      check($sformatf("tbl%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // randomized back-to-back frames, enable held high
    rx_bits = 0;
    rb = W'($urandom);
    rp = NP'($urandom);
    exp_q.push_back(model_word(rb, rp));
    buttons = rb; pad_present = rp;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_latch($sformatf("rnd%0d", i));
      // new inputs land during LATCH, ahead of the next LOAD
      rb = W'($urandom);
      rp = NP'($urandom_range(0, 3));
      exp_q.push_back(model_word(rb, rp));
      buttons = rb; pad_present = rp;
      check($sformatf("rnd%0d_word", i), 32'(rx_word), 32'(exp_q.pop_front()));
      check($sformatf("rnd%0d_bits", i), 32'(rx_frame_bits), 32'd24);
      if (i >= 1) check($sformatf("rnd%0d_latch_len", i), 32'(last_lat_len), 32'(CDIV));
      if (i >= 2) check($sformatf("rnd%0d_period", i), 32'(last_done_gap), 32'(PERIOD));
    end
    enable = 1'b0;
    cyc_wait(PERIOD + 10);
    check("rnd_idle_busy", 32'(busy), 32'd0);

    // buttons change after LOAD: snapshot sent, new value on next frame
    rx_bits = 0;
    buttons = 24'h0A53C3; pad_present = 2'b11;
    nb = 24'h5C1A0E;
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      cyc_wait(1);
      if (busy) got = 1'b1;
    end
    check("snap_busy_timeout", 32'(got), 32'd1);
    cyc_wait(10);
    buttons = nb;
    wait_latch("snap0");
    check("snap0_word", 32'(rx_word), 32'(model_word(24'h0A53C3, 2'b11)));
    wait_latch("snap1");
    enable = 1'b0;
    check("snap1_word", 32'(rx_word), 32'(model_word(nb, 2'b11)));
    cyc_wait(PERIOD);

    // drop enable during BIT_HIGH of bit 5
    rx_bits = 0;
    buttons = 24'h123456; pad_present = 2'b11;
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc_wait(1);
      if (rx_bits == 5 && pif.pmod_clk) got = 1'b1;
    end
    check("drop_bit5_timeout", 32'(got), 32'd1);
    enable = 1'b0;
    l0 = latch_cnt; d0 = done_cnt;
    wait_latch("drop");
    cyc_wait(GAP + 3 * CDIV + 20);
    check("drop_word",    32'(rx_word), 32'h123456);
    check("drop_latches", 32'(latch_cnt - l0), 32'd1);
    check("drop_dones",   32'(done_cnt - d0), 32'd1);
    check("drop_busy",    32'(busy), 32'd0);
    check("drop_lines",   32'({pif.pmod_data, pif.pmod_clk, pif.pmod_latch}), 32'd0);

    // one-cycle reset during BIT_HIGH aborts without a latch edge
    rx_bits = 0;
    buttons = 24'hABCDEF; pad_present = 2'b11;
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      cyc_wait(1);
      if (pif.pmod_clk) got = 1'b1;
    end
    check("rst_mid_timeout", 32'(got), 32'd1);
    l0 = latch_cnt;
    enable = 1'b0;
    rst_n  = 1'b0;
    cyc_wait(1);
    check("rst_mid_clk",   32'(pif.pmod_clk),   32'd0);
    check("rst_mid_latch", 32'(pif.pmod_latch), 32'd0);
    check("rst_mid_busy",  32'(busy),           32'd0);
    rst_n = 1'b1;
    cyc_wait(PERIOD + 20);
    check("rst_mid_no_latch", 32'(latch_cnt - l0), 32'd0);
    check("rst_mid_idle",     32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gamepad_pmod_emulator.md
Name: gamepad_pmod_emulator

Overview:
- Transmit-side counterpart of the gamepad Pmod receive path.
- Serializes parallel button states for 1 or 2 virtual controllers onto the 3-wire Pmod protocol (pmod_data, pmod_clk, pmod_latch).
- Drives gamepad_pmod_single/dual directly in simulation, in the playground's keyboard-to-gamepad bridge, and in loopback self-test.
- Runs in the receiver's clock domain, but its timing also satisfies the receiver's 2-flop synchronizers when the two blocks are on different clocks.

Parameters:
- NUM_PADS, 2, number of controllers serialized (1 or 2); frame width W = 12*NUM_PADS.
- CLK_DIV, 4, clk cycles per pmod_clk half-period and per latch pulse; must be >= 3.
- FRAME_GAP, 64, idle clk cycles after each latch pulse before the next frame starts; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: synchronous, active-low.
- enable  input  1  1 = transmit frames back-to-back; 0 = stop after the current frame.
- buttons  input  12*NUM_PADS  pad p occupies [12p+11:12p], MSB..LSB = b,y,select,start,up,down,left,right,a,x,l,r; 1 = pressed.
- pad_present  input  NUM_PADS  0 = pad absent; its 12 bits are transmitted as all 1s.
- pmod_data  output  1  serial data, MSB of the frame first.
- pmod_clk  output  1  serial clock; the receiver samples on its rising edge.
- pmod_latch  output  1  high pulse after the last bit; the receiver transfers on its rising edge.
- busy  output  1  high from LOAD through LATCH.
- frame_done  output  1  one-cycle pulse in the first GAP cycle.

Behaviour:
- All outputs are registered flops, with no combinational paths to the pins.
- Reset value of every output is 0. Reset state is IDLE.
- Reset mid-frame aborts the frame on the next edge. The lines return low and no latch edge is produced.
- Frame word: for each p, word[12p+11:12p] = pad_present[p] ? buttons[12p+11:12p] : 12'hFFF. Bit W-1 is sent first, so pad 1 is followed by pad 0 when NUM_PADS=2.
- FSM states and transitions:
  - IDLE: all lines 0, busy 0. Goes to LOAD on the cycle after enable=1 is sampled.
  - LOAD (1 cycle): snapshots the frame word into the shift register and sets bit_cnt=W, busy=1. Goes to BIT_LOW. Changes to buttons or pad_present after this cycle are ignored until the next LOAD.
  - BIT_LOW (CLK_DIV cycles): pmod_clk=0, pmod_data=shift[W-1]. Goes to BIT_HIGH.
  - BIT_HIGH (CLK_DIV cycles): pmod_clk=1, pmod_data unchanged. On exit, shift left by 1 and decrement bit_cnt. Goes to BIT_LOW if bit_cnt != 0, else to LATCH. Data is therefore stable CLK_DIV cycles before and after every rising edge.
  - LATCH (CLK_DIV cycles): pmod_latch=1, pmod_clk=0, pmod_data=0. Goes to GAP.
  - GAP (FRAME_GAP cycles): all lines 0, busy=0, frame_done=1 in the first cycle only. On exit, goes to LOAD if enable=1, else IDLE.
- Frame period is 1 + 2*CLK_DIV*W + CLK_DIV + FRAME_GAP cycles. With defaults and NUM_PADS=2 this is 261.
- enable only gates entry into LOAD. Dropping enable mid-frame still completes that frame, including the latch.
- A single down-counter of width clog2(max(CLK_DIV, FRAME_GAP)) times all phases. bit_cnt is clog2(W+1) bits. The counter is reloaded on every state change.
- A present pad with all 12 buttons pressed is sent as 12'hFFF and decodes as "not present" downstream. This is an accepted protocol limitation and is not masked.

Decomposition:
- Package gamepad_pmod_pkg holds:
  - PAD_BITS = 12.
  - ABSENT_WORD = 12'hFFF.
  - Button bit-index localparams BTN_B=11 through BTN_R=0.
  - The FSM state enum.
- The receive modules will use the same constants.
- No sub-module; a single FSM and counter are sufficient.

Test Plan:
- Loopback into gamepad_pmod_dual on the same clk. Pad0 buttons = 12'h801 (b, r), pad1 = 12'h010 (right), both present, enable=1 -> after the first latch: b[0]=1, r[0]=1, right[1]=1, all others 0, is_present=2'b11.
- pad_present=2'b01 with pad1 buttons = 12'h0F0 -> pad1 decodes is_present[1]=0 and all its buttons 0. Bits 23:12 on the wire are all 1.
- Defaults, NUM_PADS=2, enable held high -> frame_done pulses exactly every 261 cycles. Exactly 24 pmod_clk rising edges occur between consecutive pmod_latch rising edges, and pmod_latch is high for 4 cycles.
- Change buttons mid-frame (after LOAD) -> the transmitted frame equals the LOAD snapshot, and the new value appears in the next frame.
- Drop enable during BIT_HIGH of bit 5 -> the frame completes, the latch is emitted, frame_done pulses once, then IDLE with all lines 0 and busy=0.
- Assert rst_n=0 for 1 cycle during BIT_HIGH -> the next cycle shows pmod_clk=0, pmod_latch=0, busy=0. The receiver's data_reg is unchanged (no latch edge).
